// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the requester-side cache fill controller:
//   - default block / address widths (must match the read-only cache)
//   - width of the optional hit/miss statistics counters
//   - fill FSM state encoding
//   - saturating increment helper for the statistics counters
// No ports (package).
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam int SIZE_BLOCK_DEF = 32;
    localparam int BIT_TOTAL_DEF  = 24;
    localparam int STAT_W         = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        CHECK    = 3'd2,
        MEM_REQ  = 3'd3,
        MEM_WAIT = 3'd4,
        FILL     = 3'd5,
        RESP     = 3'd6
    } fill_state_t;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val);
        if (val == {STAT_W{1'b1}}) begin
            sat_inc = val;
        end else begin
            sat_inc = val + {{(STAT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/cache_fill_stats.sv
// -----------------------------------------------------------------------------
// cache_fill_stats
// Saturating hit / miss counter pair for the cache fill controller.
// Only instantiated when CACHE_FILL_STATS_EN is defined.
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous reset, active-low
//   hit_inc     in   count one hit this cycle
//   miss_inc    in   count one miss this cycle
//   stat_hits   out  STAT_W  number of hits (saturating)
//   stat_misses out  STAT_W  number of misses (saturating)
// -----------------------------------------------------------------------------
module cache_fill_stats
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              hit_inc,
    input  logic              miss_inc,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_misses
);

    logic [STAT_W-1:0] hits_r;
    logic [STAT_W-1:0] misses_r;

    // Counter registers; each counts independently and saturates at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hits_r   <= {STAT_W{1'b0}};
            misses_r <= {STAT_W{1'b0}};
        end else begin
            if (hit_inc) begin
                hits_r <= sat_inc(hits_r);
            end
            if (miss_inc) begin
                misses_r <= sat_inc(misses_r);
            end
        end
    end

    assign stat_hits   = hits_r;
    assign stat_misses = misses_r;

endmodule

// File: rtl/cache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_fill_ctrl
// Requester-side controller for the read-only block cache. Accepts one block
// read at a time, probes the cache, and on a miss fetches the block from
// external memory over an Avalon-MM-style read master, writes it into the
// cache, then returns it to the client. All outputs are registered.
//
// Optional feature: define CACHE_FILL_STATS_EN to add saturating
// stat_hits / stat_misses counter ports.
//
// Ports:
//   clk, rst (sync, active-low)
//   req_valid/req_ready/req_addr            client request
//   resp_valid/resp_ready/resp_data/resp_hit client response (hit=1: from cache)
//   c_en/c_wrt/c_addr/c_data                 cache access (c_wrt=1: fill)
//   c_rdata/c_success                        cache read data / hit flag (1 cycle later)
//   mem_read/mem_addr/mem_waitrequest        memory read command
//   mem_readdatavalid/mem_readdata           memory read return
//   stat_hits/stat_misses                    (CACHE_FILL_STATS_EN only)
// -----------------------------------------------------------------------------
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int SIZE_BLOCK = SIZE_BLOCK_DEF,
    parameter int BIT_TOTAL  = BIT_TOTAL_DEF
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [BIT_TOTAL-1:0]  req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [SIZE_BLOCK-1:0] resp_data,
    output logic                  resp_hit,
    output logic                  c_en,
    output logic                  c_wrt,
    output logic [BIT_TOTAL-1:0]  c_addr,
    output logic [SIZE_BLOCK-1:0] c_data,
    input  logic [SIZE_BLOCK-1:0] c_rdata,
    input  logic                  c_success,
    output logic                  mem_read,
    output logic [BIT_TOTAL-1:0]  mem_addr,
    input  logic                  mem_waitrequest,
    input  logic                  mem_readdatavalid,
    input  logic [SIZE_BLOCK-1:0] mem_readdata
`ifdef CACHE_FILL_STATS_EN
    ,
    output logic [STAT_W-1:0]     stat_hits,
    output logic [STAT_W-1:0]     stat_misses
`endif
);

    fill_state_t           state_r;
    fill_state_t           state_nxt;
    logic [BIT_TOTAL-1:0]  addr_r;
    logic [BIT_TOTAL-1:0]  addr_nxt;
    logic [SIZE_BLOCK-1:0] data_r;
    logic [SIZE_BLOCK-1:0] data_nxt;
    logic                  hit_r;
    logic                  hit_nxt;
    logic                  check_hit_s;

    // Hit decode: an X or Z hit flag compares as not-equal and takes the miss path.
    always_comb begin
        if (c_success == 1'b1) begin
            check_hit_s = 1'b1;
        end else begin
            check_hit_s = 1'b0;
        end
    end

    // Next-state and datapath-capture logic of the fill FSM.
    always_comb begin
        state_nxt = state_r;
        addr_nxt  = addr_r;
        data_nxt  = data_r;
        hit_nxt   = hit_r;
        case (state_r)
            IDLE: begin
                // req_ready is registered, so it is low for the first IDLE
                // cycle after reset and a request is not taken then.
                if (req_valid && req_ready) begin
                    addr_nxt  = req_addr;
                    state_nxt = LOOKUP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            LOOKUP: begin
                state_nxt = CHECK;
            end
            CHECK: begin
                if (check_hit_s) begin
                    data_nxt  = c_rdata;
                    hit_nxt   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    hit_nxt   = 1'b0;
                    state_nxt = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (!mem_waitrequest) begin
                    state_nxt = MEM_WAIT;
                end else begin
                    state_nxt = MEM_REQ;
                end
            end
            MEM_WAIT: begin
                if (mem_readdatavalid) begin
                    data_nxt  = mem_readdata;
                    state_nxt = FILL;
                end else begin
                    state_nxt = MEM_WAIT;
                end
            end
            FILL: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RESP;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and captured-request registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            addr_r  <= {BIT_TOTAL{1'b0}};
            data_r  <= {SIZE_BLOCK{1'b0}};
            hit_r   <= 1'b0;
        end else begin
            state_r <= state_nxt;
            addr_r  <= addr_nxt;
            data_r  <= data_nxt;
            hit_r   <= hit_nxt;
        end
    end

    // Output registers, decoded from the next state so each output is
    // valid for exactly the cycles its state is occupied.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_data  <= {SIZE_BLOCK{1'b0}};
            c_en       <= 1'b0;
            c_wrt      <= 1'b0;
            c_addr     <= {BIT_TOTAL{1'b0}};
            c_data     <= {SIZE_BLOCK{1'b0}};
            mem_read   <= 1'b0;
            mem_addr   <= {BIT_TOTAL{1'b0}};
        end else begin
            req_ready  <= (state_nxt == IDLE);
            resp_valid <= (state_nxt == RESP);
            resp_hit   <= hit_nxt;
            resp_data  <= data_nxt;
            c_en       <= (state_nxt == LOOKUP) || (state_nxt == FILL);
            c_wrt      <= (state_nxt == FILL);
            c_addr     <= addr_nxt;
            c_data     <= data_nxt;
            mem_read   <= (state_nxt == MEM_REQ);
            mem_addr   <= addr_nxt;
        end
    end

`ifdef CACHE_FILL_STATS_EN
    logic hit_inc_s;
    logic miss_inc_s;

    // Count on the CHECK decision: CHECK->RESP is a hit, CHECK->MEM_REQ a miss.
    always_comb begin
        if (state_r == CHECK) begin
            hit_inc_s  = check_hit_s;
            miss_inc_s = !check_hit_s;
        end else begin
            hit_inc_s  = 1'b0;
            miss_inc_s = 1'b0;
        end
    end

    cache_fill_stats u_stats (
        .clk         (clk),
        .rst         (rst),
        .hit_inc     (hit_inc_s),
        .miss_inc    (miss_inc_s),
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
    );
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_ctrl
// Self-checking bench for cache_fill_ctrl. A direct-mapped cache model
// (32 lines, 5 index bits) and an Avalon-style memory model with configurable
// waitrequest count W and return delay D surround the controller. D counts the
// memory acceptance cycle as cycle 1, so a miss responds 3+W+D cycles after
// the request is accepted. Expected responses go into a scoreboard queue when
// a request is accepted and are popped when resp_valid appears.
// -----------------------------------------------------------------------------
module tb_cache_fill_ctrl;
    import cache_pkg::*;

    localparam int SB = 32;
    localparam int BT = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [BT-1:0] req_addr;
    logic          resp_valid;
    logic          resp_ready;
    logic [SB-1:0] resp_data;
    logic          resp_hit;
    logic          c_en;
    logic          c_wrt;
    logic [BT-1:0] c_addr;
    logic [SB-1:0] c_data;
    logic [SB-1:0] c_rdata = '0;
    logic          c_success = 1'b0;
    logic          mem_read;
    logic [BT-1:0] mem_addr;
    logic          mem_waitrequest;
    logic          mem_readdatavalid;
    logic [SB-1:0] mem_readdata;
`ifdef CACHE_FILL_STATS_EN
    logic [31:0]   stat_hits;
    logic [31:0]   stat_misses;
`endif

    always #5 clk = ~clk;

    cache_fill_ctrl #(.SIZE_BLOCK(SB), .BIT_TOTAL(BT)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_data         (resp_data),
        .resp_hit          (resp_hit),
        .c_en              (c_en),
        .c_wrt             (c_wrt),
        .c_addr            (c_addr),
        .c_data            (c_data),
        .c_rdata           (c_rdata),
        .c_success         (c_success),
        .mem_read          (mem_read),
        .mem_addr          (mem_addr),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdatavalid (mem_readdatavalid),
        .mem_readdata      (mem_readdata)
`ifdef CACHE_FILL_STATS_EN
        ,
        .stat_hits         (stat_hits),
        .stat_misses       (stat_misses)
`endif
    );

    // ---------------- cache model: direct mapped, 32 lines ----------------
    logic [SB-1:0] cm_data  [32];
    logic [18:0]   cm_tag   [32];
    logic [31:0]   cm_valid = '0;
    int            fill_cnt = 0;
    logic [BT-1:0] fill_addr = '0;
    logic [SB-1:0] fill_data = '0;

    always @(posedge clk) begin
        if (c_en) begin
            if (c_wrt) begin
                cm_data[c_addr[4:0]]  <= c_data;
                cm_tag[c_addr[4:0]]   <= c_addr[23:5];
                cm_valid[c_addr[4:0]] <= 1'b1;
                fill_cnt  <= fill_cnt + 1;
                fill_addr <= c_addr;
                fill_data <= c_data;
            end else begin
                c_rdata   <= cm_data[c_addr[4:0]];
                c_success <= cm_valid[c_addr[4:0]] && (cm_tag[c_addr[4:0]] == c_addr[23:5]);
            end
        end
    end

    // ---------------- memory model ----------------
    int            wr_cfg = 0;
    int            d_cfg = 2;
    int            wait_cnt = 0;
    int            pend_cnt = 0;
    logic          pending = 1'b0;
    logic [SB-1:0] pend_data = '0;
    logic          inject_rdv = 1'b0;
    int            mem_acc_cnt = 0;
    logic [BT-1:0] mem_addr_seen = '0;

    function automatic logic [SB-1:0] mem_val(input logic [BT-1:0] a);
        case (a)
            24'd3:   mem_val = 32'h0000_000a;
            24'd32:  mem_val = 32'h0000_0001;
            24'd64:  mem_val = 32'h0000_0002;
            24'd96:  mem_val = 32'h0000_0003;
            default: mem_val = {8'h5a, a};
        endcase
    endfunction

    always_comb mem_waitrequest = mem_read && (wait_cnt < wr_cfg);
    always_comb mem_readdatavalid = (pending && (pend_cnt == 0)) || inject_rdv;
    always_comb mem_readdata = inject_rdv ? 32'hdead_beef : pend_data;

    always @(posedge clk) begin
        if (mem_read && mem_waitrequest) begin
            wait_cnt <= wait_cnt + 1;
        end else if (mem_read) begin
            wait_cnt      <= 0;
            pending       <= 1'b1;
            pend_cnt      <= d_cfg - 2;
            pend_data     <= mem_val(mem_addr);
            mem_acc_cnt   <= mem_acc_cnt + 1;
            mem_addr_seen <= mem_addr;
        end else if (pending) begin
            if (pend_cnt == 0) pending <= 1'b0;
            else pend_cnt <= pend_cnt - 1;
        end
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [BT-1:0] addr;
        int            wr;
        int            d;
        logic [SB-1:0] exp_data;
        logic          exp_hit;
        int            exp_lat;
        int            hold;
    } vec_t;

    typedef struct {
        logic [SB-1:0] data;
        logic          hit;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_req(input vec_t v, input string tag);
        int   n;
        int   acc0;
        int   fill0;
        int   bad;
        exp_t e;
        wr_cfg     = v.wr;
        d_cfg      = v.d;
        acc0       = mem_acc_cnt;
        fill0      = fill_cnt;
        resp_ready = (v.hold == 0);
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_addr  = v.addr;
        @(posedge clk);
        sb_q.push_back('{v.exp_data, v.exp_hit});
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (resp_valid !== 1'b1 && n < 200);
        check({tag, " latency"}, 64'(n), 64'(v.exp_lat));
        e = sb_q.pop_front();
        check({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
        check({tag, " resp_data"}, 64'(resp_data), 64'(e.data));
        check({tag, " resp_hit"}, 64'(resp_hit), 64'(e.hit));
        if (v.hold > 0) begin
            bad = 0;
            repeat (v.hold) begin
                @(negedge clk);
                if (resp_valid !== 1'b1 || resp_data !== e.data || req_ready !== 1'b0) bad++;
            end
            check({tag, " held response unstable cycles"}, 64'(bad), 64'd0);
            resp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, " resp done"}, 64'(resp_valid), 64'd0);
        check({tag, " mem accepts"}, 64'(mem_acc_cnt - acc0), v.exp_hit ? 64'd0 : 64'd1);
        check({tag, " fills"}, 64'(fill_cnt - fill0), v.exp_hit ? 64'd0 : 64'd1);
        if (!v.exp_hit) begin
            check({tag, " mem_addr"}, 64'(mem_addr_seen), 64'(v.addr));
            check({tag, " fill c_addr"}, 64'(fill_addr), 64'(v.addr));
            check({tag, " fill c_data"}, 64'(fill_data), 64'(v.exp_data));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rec;
        int   n;
        int   acc0;
        int   fill0;
        int   bad;

        //           addr    W  D  data           hit   lat hold
        vecs[0] = '{24'd3,  2, 3, 32'h0000_000a, 1'b0, 8, 0};
        vecs[1] = '{24'd3,  0, 2, 32'h0000_000a, 1'b1, 2, 0};
        vecs[2] = '{24'd32, 0, 2, 32'h0000_0001, 1'b0, 5, 0};
        vecs[3] = '{24'd64, 1, 2, 32'h0000_0002, 1'b0, 6, 0};
        vecs[4] = '{24'd96, 0, 4, 32'h0000_0003, 1'b0, 7, 0};
        vecs[5] = '{24'd64, 0, 2, 32'h0000_0002, 1'b0, 5, 0};
        vecs[6] = '{24'd3,  0, 2, 32'h0000_000a, 1'b1, 2, 4};
        rec     = '{24'd3,  0, 2, 32'h0000_000a, 1'b1, 2, 0};

        rst        = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b1;

        // Reset: everything zero while held, req_ready one cycle after release.
        repeat (5) @(negedge clk);
        check("rst req_ready", 64'(req_ready), 64'd0);
        check("rst resp_valid", 64'(resp_valid), 64'd0);
        check("rst resp_hit", 64'(resp_hit), 64'd0);
        check("rst resp_data", 64'(resp_data), 64'd0);
        check("rst c_en", 64'(c_en), 64'd0);
        check("rst c_wrt", 64'(c_wrt), 64'd0);
        check("rst c_addr", 64'(c_addr), 64'd0);
        check("rst c_data", 64'(c_data), 64'd0);
        check("rst mem_read", 64'(mem_read), 64'd0);
        check("rst mem_addr", 64'(mem_addr), 64'd0);
`ifdef CACHE_FILL_STATS_EN
        check("rst stat_hits", 64'(stat_hits), 64'd0);
        check("rst stat_misses", 64'(stat_misses), 64'd0);
`endif
        rst = 1'b1;
        check("release req_ready before edge", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("release req_ready after edge", 64'(req_ready), 64'd1);

        // Cold miss, hit, conflicting misses, held response.
        for (int i = 0; i < 7; i++) begin
            do_req(vecs[i], $sformatf("vec%0d", i));
`ifdef CACHE_FILL_STATS_EN
            if (i == 5) begin
                check("stat_hits after misses", 64'(stat_hits), 64'd1);
                check("stat_misses after misses", 64'(stat_misses), 64'd5);
            end
`endif
        end

        // Reset while waiting for memory data; late and injected data ignored.
        wr_cfg = 0;
        d_cfg  = 12;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc0      = mem_acc_cnt;
        req_valid = 1'b1;
        req_addr  = 24'd200;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (mem_acc_cnt == acc0 && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        check("abort mem accepted", 64'(mem_acc_cnt - acc0), 64'd1);
        fill0 = fill_cnt;
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("abort rst mem_read", 64'(mem_read), 64'd0);
        check("abort rst resp_valid", 64'(resp_valid), 64'd0);
        rst = 1'b1;
        @(negedge clk) inject_rdv = 1'b1;
        @(negedge clk) inject_rdv = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (resp_valid === 1'b1 || c_wrt === 1'b1 || c_en === 1'b1) bad++;
        end
        check("abort stray activity cycles", 64'(bad), 64'd0);
        check("abort fills", 64'(fill_cnt - fill0), 64'd0);
        check("abort req_ready", 64'(req_ready), 64'd1);

        // Recovery after the aborted fill.
        do_req(rec, "recover");

`ifdef CACHE_FILL_STATS_EN
        @(negedge clk);
        force dut.u_stats.hits_r = 32'hffff_fffe;
        @(negedge clk);
        release dut.u_stats.hits_r;
        do_req(rec, "sat1");
        do_req(rec, "sat2");
        check("stat_hits saturated", 64'(stat_hits), 64'hffff_ffff);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
